// File: rtl/reg_fetch_stage_pkg.sv
// Shared processor package for the register-fetch stage.
// Holds the default width constants and the immediate-extension mode
// encodings used by reg_fetch_stage and imm_extend.
package reg_fetch_stage_pkg;

    localparam int DEF_REG_INDEX_BIT_WIDTH = 4;
    localparam int DEF_DBITS               = 32;
    localparam int DEF_IMM_BITS            = 16;

    // Immediate extension modes carried on imm_mode.
    typedef enum logic [1:0] {
        IMM_SEXT     = 2'b00,   // sign-extend
        IMM_ZEXT     = 2'b01,   // zero-extend
        IMM_UPPER    = 2'b10,   // place raw immediate in the top bits
        IMM_SEXT_SH2 = 2'b11    // sign-extend, then shift left by 2
    } imm_mode_t;

endpackage

// File: rtl/reg_fetch_stage_imm_extend.sv
// imm_extend: purely combinational immediate extender.
// Ports:
//   imm_in   [IMM_BITS-1:0]  raw immediate from the decoder
//   imm_mode [1:0]           extension mode (see imm_mode_t)
//   imm_out  [DBITS-1:0]     extended immediate
module imm_extend
    import reg_fetch_stage_pkg::*;
#(
    parameter int DBITS    = DEF_DBITS,
    parameter int IMM_BITS = DEF_IMM_BITS
) (
    input  logic [IMM_BITS-1:0] imm_in,
    input  logic [1:0]          imm_mode,
    output logic [DBITS-1:0]    imm_out
);

    logic [DBITS-1:0] sext;
    logic [DBITS-1:0] zext;
    logic [DBITS-1:0] upper;

    assign sext  = {{(DBITS-IMM_BITS){imm_in[IMM_BITS-1]}}, imm_in};
    assign zext  = {{(DBITS-IMM_BITS){1'b0}}, imm_in};
    assign upper = {imm_in, {(DBITS-IMM_BITS){1'b0}}};

    always_comb begin
        imm_out = sext;
        case (imm_mode)
            IMM_SEXT:     imm_out = sext;
            IMM_ZEXT:     imm_out = zext;
            IMM_UPPER:    imm_out = upper;
            IMM_SEXT_SH2: imm_out = sext << 2;   // top bits simply fall off
            default:      imm_out = sext;
        endcase
    end

endmodule

// File: rtl/reg_fetch_stage.sv
// reg_fetch_stage: register-file read stage with a busy-bit scoreboard.
// Reads rd/rs1/rs2 (with same-cycle writeback bypass), extends the
// immediate and presents everything one cycle after acceptance through a
// valid/ready output register. Instructions that touch a busy register
// are stalled until the pending writeback arrives.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   in_valid / in_ready        input handshake (in_ready is combinational)
//   rd, rs1, rs2, rd_write     register indices, rd will be written later
//   imm_in, imm_mode           raw immediate and its extension mode
//   wb_en, wb_idx, wb_data     writeback port
//   out_valid / out_ready      output handshake
//   out_regd/out_reg1/out_reg2 operand values, out_imm, out_rd
module reg_fetch_stage
    import reg_fetch_stage_pkg::*;
#(
    parameter int REG_INDEX_BIT_WIDTH = DEF_REG_INDEX_BIT_WIDTH,
    parameter int DBITS               = DEF_DBITS,
    parameter int IMM_BITS            = DEF_IMM_BITS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] rd,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] rs1,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] rs2,
    input  logic                           rd_write,
    input  logic [IMM_BITS-1:0]            imm_in,
    input  logic [1:0]                     imm_mode,
    input  logic                           wb_en,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] wb_idx,
    input  logic [DBITS-1:0]               wb_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DBITS-1:0]               out_regd,
    output logic [DBITS-1:0]               out_reg1,
    output logic [DBITS-1:0]               out_reg2,
    output logic [DBITS-1:0]               out_imm,
    output logic [REG_INDEX_BIT_WIDTH-1:0] out_rd
);

    localparam int NREGS = 2 ** REG_INDEX_BIT_WIDTH;

    // Register file is flop-based: every entry must clear on reset.
    logic [DBITS-1:0] regs_reg [NREGS];
    logic [NREGS-1:0] busy_reg;

    logic [NREGS-1:0] wb_hit;     // one-hot decode of this cycle's writeback
    logic [NREGS-1:0] set_hit;    // one-hot decode of this cycle's busy set
    logic [NREGS-1:0] busy_eff;   // busy after same-cycle writeback clears

    logic             hazard;
    logic             accept;
    logic [DBITS-1:0] imm_ext;
    logic [DBITS-1:0] regd_val;
    logic [DBITS-1:0] reg1_val;
    logic [DBITS-1:0] reg2_val;

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            assign wb_hit[gi]   = wb_en && (wb_idx == REG_INDEX_BIT_WIDTH'(gi));
            assign set_hit[gi]  = accept && rd_write && (rd == REG_INDEX_BIT_WIDTH'(gi));
            assign busy_eff[gi] = busy_reg[gi] && !wb_hit[gi];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    regs_reg[gi] <= '0;
                end else if (wb_hit[gi]) begin
                    regs_reg[gi] <= wb_data;
                end
            end

            // A new producer claiming the register outranks the old
            // producer's writeback landing in the same cycle.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    busy_reg[gi] <= 1'b0;
                end else if (set_hit[gi]) begin
                    busy_reg[gi] <= 1'b1;
                end else if (wb_hit[gi]) begin
                    busy_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign hazard   = in_valid && (busy_eff[rd] || busy_eff[rs1] || busy_eff[rs2]);
    assign in_ready = (!out_valid || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    // Writeback bypass so an operand written this cycle is not stale.
    assign regd_val = wb_hit[rd]  ? wb_data : regs_reg[rd];
    assign reg1_val = wb_hit[rs1] ? wb_data : regs_reg[rs1];
    assign reg2_val = wb_hit[rs2] ? wb_data : regs_reg[rs2];

    imm_extend #(
        .DBITS    (DBITS),
        .IMM_BITS (IMM_BITS)
    ) u_imm_extend (
        .imm_in   (imm_in),
        .imm_mode (imm_mode),
        .imm_out  (imm_ext)
    );

    // Output register: load on acceptance, hold while stalled,
    // drop valid once the consumer has taken the data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_regd  <= '0;
            out_reg1  <= '0;
            out_reg2  <= '0;
            out_imm   <= '0;
            out_rd    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_regd  <= regd_val;
            out_reg1  <= reg1_val;
            out_reg2  <= reg2_val;
            out_imm   <= imm_ext;
            out_rd    <= rd;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_fetch_stage.sv
// Scoreboard bench for reg_fetch_stage: a behavioural model decides
// acceptance and pushes expected operands; a negedge monitor compares
// whatever the DUT presents against the head of the queue.
module tb_reg_fetch_stage;

    localparam int RW = 4;
    localparam int DW = 32;
    localparam int IW = 16;
    localparam int NR = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [RW-1:0] rd = '0, rs1 = '0, rs2 = '0;
    logic          rd_write = 1'b0;
    logic [IW-1:0] imm_in = '0;
    logic [1:0]    imm_mode = '0;
    logic          wb_en = 1'b0;
    logic [RW-1:0] wb_idx = '0;
    logic [DW-1:0] wb_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_regd, out_reg1, out_reg2, out_imm;
    logic [RW-1:0] out_rd;

    reg_fetch_stage #(
        .REG_INDEX_BIT_WIDTH (RW),
        .DBITS               (DW),
        .IMM_BITS            (IW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd_write  (rd_write),
        .imm_in    (imm_in),
        .imm_mode  (imm_mode),
        .wb_en     (wb_en),
        .wb_idx    (wb_idx),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_regd  (out_regd),
        .out_reg1  (out_reg1),
        .out_reg2  (out_reg2),
        .out_imm   (out_imm),
        .out_rd    (out_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] regd;
        logic [DW-1:0] reg1;
        logic [DW-1:0] reg2;
        logic [DW-1:0] imm;
        logic [RW-1:0] rdi;
    } exp_t;

    exp_t          sbq[$];
    logic [DW-1:0] mregs[NR];
    bit            mbusy[NR];
    int            n_cmp = 0;
    int            n_bad = 0;
    bit            mon_en = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] imm_ref(input logic [IW-1:0] v, input logic [1:0] m);
        longint s;
        s = longint'($signed(v));
        case (m)
            2'd0:    return DW'(s);
            2'd1:    return DW'(v);
            2'd2:    return DW'(longint'(v) * 65536);
            default: return DW'(s * 4);
        endcase
    endfunction

    function automatic bit still_busy(input logic [RW-1:0] idx);
        return mbusy[idx] && !(wb_en && wb_idx == idx);
    endfunction

    function automatic logic [DW-1:0] read_ref(input logic [RW-1:0] idx);
        return (wb_en && wb_idx == idx) ? wb_data : mregs[idx];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NR; i++) begin
            mregs[i] = '0;
            mbusy[i] = 1'b0;
        end
        sbq.delete();
    endtask

    // One clock cycle with the currently driven inputs; entered and left
    // 1 time unit after a rising edge.
    task automatic tick();
        bit   exp_rdy;
        exp_t e;
        exp_rdy = (sbq.size() == 0 || out_ready) &&
                  !(in_valid && (still_busy(rd) || still_busy(rs1) || still_busy(rs2)));
        @(negedge clk);
        chk("in_ready", in_ready, exp_rdy);
        @(posedge clk);
        if (in_valid && exp_rdy) begin
            e.regd = read_ref(rd);
            e.reg1 = read_ref(rs1);
            e.reg2 = read_ref(rs2);
            e.imm  = imm_ref(imm_in, imm_mode);
            e.rdi  = rd;
            sbq.push_back(e);
        end
        if (wb_en) begin
            mregs[wb_idx] = wb_data;
            mbusy[wb_idx] = 1'b0;
        end
        if (in_valid && exp_rdy && rd_write) mbusy[rd] = 1'b1;
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        rd_write = 1'b0;
        wb_en    = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic issue(input int d, input int s1, input int s2, input bit w,
                         input logic [IW-1:0] imm, input logic [1:0] m);
        in_valid = 1'b1;
        rd       = RW'(d);
        rs1      = RW'(s1);
        rs2      = RW'(s2);
        rd_write = w;
        imm_in   = imm;
        imm_mode = m;
    endtask

    task automatic writeback(input int idx, input logic [DW-1:0] data);
        wb_en   = 1'b1;
        wb_idx  = RW'(idx);
        wb_data = data;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: out_valid must track the model, and the presented data
    // must equal the queue head every cycle it is shown (covers stalls).
    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", DW'(out_valid), DW'(sbq.size() != 0));
            if (out_valid && sbq.size() != 0) begin
                chk("out_regd", out_regd, sbq[0].regd);
                chk("out_reg1", out_reg1, sbq[0].reg1);
                chk("out_reg2", out_reg2, sbq[0].reg2);
                chk("out_imm",  out_imm,  sbq[0].imm);
                chk("out_rd",   DW'(out_rd), DW'(sbq[0].rdi));
                if (out_ready) void'(sbq.pop_front());
            end
        end
    end

    initial begin
        logic [DW-1:0] imm_exp[4];
        imm_exp = '{32'hFFFFF0F0, 32'h0000F0F0, 32'hF0F00000, 32'hFFFFC3C0};

        clear_model();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_out_valid", DW'(out_valid), '0);
        chk("rst_out_regd", out_regd, '0);
        chk("rst_out_imm", out_imm, '0);
        chk("rst_out_rd", DW'(out_rd), '0);
        mon_en = 1'b1;

        // Basic read after three writebacks.
        idle();
        writeback(0, 5);  tick();
        writeback(1, 7);  tick();
        writeback(2, 9);  tick();
        wb_en = 1'b0;
        issue(0, 1, 2, 0, 16'h0000, 2'd0); tick();
        in_valid = 1'b0;
        chk("basic_valid", DW'(out_valid), 1);
        chk("basic_regd", out_regd, 5);
        chk("basic_reg1", out_reg1, 7);
        chk("basic_reg2", out_reg2, 9);
        tick();

        // Immediate modes, back to back.
        for (int m = 0; m < 4; m++) begin
            issue(0, 1, 2, 0, 16'hF0F0, 2'(m)); tick();
            chk($sformatf("imm_mode%0d", m), out_imm, imm_exp[m]);
        end
        idle(); tick();

        // RAW stall on r3 released by its writeback.
        issue(3, 0, 1, 1, 16'h0001, 2'd1); tick();
        issue(5, 3, 0, 0, 16'h0002, 2'd1);
        repeat (3) tick();
        writeback(3, 42); tick();
        chk("raw_reg1", out_reg1, 42);
        idle(); tick();

        // Output stall for three cycles, then accept on release.
        out_ready = 1'b0;
        issue(6, 1, 2, 0, 16'h1234, 2'd0); tick();
        issue(7, 1, 2, 0, 16'h8001, 2'd3);
        repeat (3) tick();
        out_ready = 1'b1; tick();
        chk("stall_out_rd", DW'(out_rd), 7);
        idle(); tick(); tick();

        // Set wins over clear on r4.
        issue(4, 0, 1, 1, 16'h0004, 2'd0);
        writeback(4, 77); tick();
        wb_en = 1'b0;
        issue(8, 4, 0, 0, 16'h0005, 2'd0); tick();
        writeback(4, 99); tick();
        chk("setwin_reg1", out_reg1, 99);
        idle(); tick();

        // Reset with output held and busy bits set.
        issue(9, 0, 0, 1, 16'h0009, 2'd0); tick();
        out_ready = 1'b0;
        issue(10, 0, 0, 1, 16'h000A, 2'd0); tick();
        do_reset();
        chk("midrst_out_valid", DW'(out_valid), 0);
        for (int i = 0; i < NR; i++) begin
            issue(i, (i + 1) % NR, (i + 2) % NR, 0, 16'(i), 2'(i));
            tick();
        end
        idle(); tick();

        // Randomized traffic.
        for (int n = 0; n < 800; n++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            rd        = RW'($urandom_range(0, NR - 1));
            rs1       = RW'($urandom_range(0, NR - 1));
            rs2       = RW'($urandom_range(0, NR - 1));
            rd_write  = ($urandom_range(0, 9) < 3);
            imm_in    = IW'($urandom);
            imm_mode  = 2'($urandom_range(0, 3));
            wb_en     = ($urandom_range(0, 9) < 4);
            wb_idx    = RW'($urandom_range(0, NR - 1));
            wb_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        idle();
        repeat (3) tick();
        chk("drain_empty", DW'(sbq.size()), 0);
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
